// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store controller: FSM encoding, default
// widths and the saturation ceiling of the event counters.
package mem_access_ctrl_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 8;
   localparam int REG_W_DEF  = 4;

   localparam logic [15:0] SAT_MAX = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ST_ISSUE = 3'd1,
      S_LD_ISSUE = 3'd2,
      S_LD_WAIT  = 3'd3,
      S_RESP     = 3'd4
   } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus bundles around the load/store controller.
//   lsu_req_if : request/response channel between execute/regfile and the
//                controller. master = requester, slave = controller.
//   lsu_mem_if : RAM access port. master = controller, slave = RAM.
interface lsu_req_if #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [15:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [REG_W-1:0]  req_rd;
   logic              resp_valid;
   logic              resp_ready;
   logic [REG_W-1:0]  resp_rd;
   logic [DATA_W-1:0] resp_data;
   logic              resp_err;
   logic              resp_we;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_rd, resp_ready,
      input  req_ready, resp_valid, resp_rd, resp_data, resp_err, resp_we
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_rd, resp_ready,
      output req_ready, resp_valid, resp_rd, resp_data, resp_err, resp_we
   );
endinterface

interface lsu_mem_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) ();
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
   modport slave (
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl_sat_counter.sv
// 16-bit event counter that sticks at SAT_MAX instead of wrapping.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   inc_i   : count one event this cycle
//   cnt_o   : current count
module sat_counter
   import mem_access_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != SAT_MAX)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the data RAM. Takes one request at a time from
// the regfile side, sequences the RAM strobes, and returns load data or a
// store acknowledge (with the destination register) to write-back.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request/response channel (slave side)
//   mem        : RAM access port (master side)
//   ld_cnt     : completed loads (saturating)
//   st_cnt     : completed stores (saturating)
//   err_cnt    : out-of-range requests (saturating)
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int REG_W    = REG_W_DEF,
   parameter int READ_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   lsu_req_if.slave    req,
   lsu_mem_if.master   mem,
   output logic [15:0] ld_cnt,
   output logic [15:0] st_cnt,
   output logic [15:0] err_cnt
);

   state_e            state_q, state_d;
   logic [2:0]        wait_q, wait_d;
   logic              we_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic [REG_W-1:0]  rd_q;

   // Any set bit above the RAM index makes the request out of range.
   logic in_range;
   assign in_range = ~|(req.req_addr >> ADDR_W);

   logic accept, resp_hs, capture;
   assign accept  = (state_q == S_IDLE) && req.req_valid;
   assign resp_hs = (state_q == S_RESP) && req.resp_ready;
   assign capture = (state_q == S_LD_WAIT) && (wait_q == 3'd0);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE: begin
            if (req.req_valid) begin
               if (!in_range)       state_d = S_RESP;
               else if (req.req_we) state_d = S_ST_ISSUE;
               else                 state_d = S_LD_ISSUE;
            end
         end
         S_ST_ISSUE: state_d = S_RESP;
         S_LD_ISSUE: begin
            // LD_WAIT always follows, so its zero-count cycle is the one
            // READ_LAT after issue, where mem_rdata is valid.
            wait_d  = 3'(READ_LAT - 1);
            state_d = S_LD_WAIT;
         end
         S_LD_WAIT: begin
            if (wait_q == 3'd0) state_d = S_RESP;
            else                wait_d  = wait_q - 3'd1;
         end
         S_RESP: if (req.resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (accept) begin
            we_q    <= req.req_we;
            err_q   <= !in_range;
            addr_q  <= req.req_addr[ADDR_W-1:0];
            wdata_q <= req.req_wdata;
            rd_q    <= req.req_rd;
            // Cleared here so stores and errors answer with zero data.
            rdata_q <= '0;
         end
         if (capture) rdata_q <= mem.mem_rdata;
      end
   end

   // Strobes are gated by rst_n so the RAM cannot be written during reset.
   assign req.req_ready  = rst_n && (state_q == S_IDLE);
   assign req.resp_valid = rst_n && (state_q == S_RESP);
   assign req.resp_rd    = rd_q;
   assign req.resp_data  = rdata_q;
   assign req.resp_err   = err_q;
   assign req.resp_we    = we_q;

   assign mem.mem_en    = rst_n && ((state_q == S_ST_ISSUE) || (state_q == S_LD_ISSUE));
   assign mem.mem_we    = rst_n && (state_q == S_ST_ISSUE);
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   sat_counter u_ld_cnt (
      .clk_i (clk), .rst_ni(rst_n),
      .inc_i (resp_hs && !err_q && !we_q), .cnt_o(ld_cnt)
   );
   sat_counter u_st_cnt (
      .clk_i (clk), .rst_ni(rst_n),
      .inc_i (resp_hs && !err_q && we_q), .cnt_o(st_cnt)
   );
   sat_counter u_err_cnt (
      .clk_i (clk), .rst_ni(rst_n),
      .inc_i (resp_hs && err_q), .cnt_o(err_cnt)
   );

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   localparam int RL = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   lsu_req_if #(.DATA_W(16), .REG_W(4))  rif  ();
   lsu_mem_if #(.DATA_W(16), .ADDR_W(8)) mif  ();
   lsu_req_if #(.DATA_W(16), .REG_W(4))  rif1 ();
   lsu_mem_if #(.DATA_W(16), .ADDR_W(8)) mif1 ();
   logic [15:0] ld_cnt, st_cnt, err_cnt;
   logic [15:0] ld_cnt1, st_cnt1, err_cnt1;

   mem_access_ctrl #(.DATA_W(16), .ADDR_W(8), .REG_W(4), .READ_LAT(RL)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(rif), .mem(mif),
      .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err_cnt(err_cnt)
   );
   mem_access_ctrl #(.DATA_W(16), .ADDR_W(8), .REG_W(4), .READ_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(rif1), .mem(mif1),
      .ld_cnt(ld_cnt1), .st_cnt(st_cnt1), .err_cnt(err_cnt1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] init_val(input int i);
      if (i == 5) return 16'h1234;
      return 16'(i * 16'h0101) ^ 16'h5A5A;
   endfunction

   // RAM models: write on mem_en&mem_we, read data appears READ_LAT cycles later.
   logic [15:0] ram [256];
   logic [15:0] rpipe [RL];
   logic [15:0] rdata1;
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      end else if (mif.mem_en && mif.mem_we) begin
         ram[mif.mem_addr] <= mif.mem_wdata;
      end
      rpipe[0] <= ram[mif.mem_addr];
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
      rdata1 <= ram[mif1.mem_addr];
   end
   assign mif.mem_rdata  = rpipe[RL-1];
   assign mif1.mem_rdata = rdata1;

   // resp_ready: 0 = always ready, 1 = random, 2 = held low
   int rr_mode = 0;
   always @(posedge clk) begin
      #2;
      case (rr_mode)
         1:       rif.resp_ready = ($urandom % 4) != 0;
         2:       rif.resp_ready = 1'b0;
         default: rif.resp_ready = 1'b1;
      endcase
   end

   // Transaction-level reference model: one outstanding request with its
   // predicted issue and response cycles, a shadow memory and event counts.
   logic [15:0] mmem [256];
   initial for (int i = 0; i < 256; i++) mmem[i] = init_val(i);

   logic        m_busy = 1'b0;
   logic        m_we, m_err;
   logic [15:0] m_addr, m_wdata, m_data;
   logic [3:0]  m_rd;
   int          m_issue, m_resp;
   int          m_ld = 0, m_st = 0, m_ec = 0;
   bit          rst_prev = 1'b0;

   function automatic logic [15:0] sat(input int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   always @(negedge clk) begin
      logic exp_en, exp_rv;
      if (!rst_n) begin
         chk("rst_req_ready", rif.req_ready, 0);
         chk("rst_mem_en", mif.mem_en, 0);
         chk("rst_mem_we", mif.mem_we, 0);
         if (rst_prev) begin
            chk("rst_resp_valid", rif.resp_valid, 0);
            chk("rst_cnts", {ld_cnt, st_cnt ^ err_cnt}, 0);
         end
         m_busy = 1'b0; m_ld = 0; m_st = 0; m_ec = 0;
         rst_prev = 1'b1;
      end else begin
         rst_prev = 1'b0;
         chk("req_ready", rif.req_ready, !m_busy);
         exp_en = m_busy && !m_err && (cyc == m_issue);
         chk("mem_en", mif.mem_en, exp_en);
         chk("mem_we", mif.mem_we, exp_en && m_we);
         if (exp_en) begin
            chk("mem_addr", mif.mem_addr, m_addr[7:0]);
            if (m_we) chk("mem_wdata", mif.mem_wdata, m_wdata);
         end
         exp_rv = m_busy && (cyc >= m_resp);
         chk("resp_valid", rif.resp_valid, exp_rv);
         if (exp_rv) begin
            chk("resp_rd", rif.resp_rd, m_rd);
            chk("resp_we", rif.resp_we, m_we);
            chk("resp_err", rif.resp_err, m_err);
            chk("resp_data", rif.resp_data, (m_err || m_we) ? 16'h0 : m_data);
         end
         chk("ld_cnt", ld_cnt, sat(m_ld));
         chk("st_cnt", st_cnt, sat(m_st));
         chk("err_cnt", err_cnt, sat(m_ec));
         if (exp_rv && rif.resp_ready) begin
            m_busy = 1'b0;
            if (m_err)     m_ec++;
            else if (m_we) m_st++;
            else           m_ld++;
         end else if (!m_busy && rif.req_valid) begin
            m_busy  = 1'b1;
            m_we    = rif.req_we;
            m_addr  = rif.req_addr;
            m_wdata = rif.req_wdata;
            m_rd    = rif.req_rd;
            m_err   = rif.req_addr >= 16'd256;
            m_issue = cyc + 1;
            m_resp  = m_err ? cyc + 1 : (m_we ? cyc + 2 : cyc + 2 + RL);
            m_data  = 16'h0;
            if (!m_err && m_we)  mmem[m_addr[7:0]] = m_wdata;
            if (!m_err && !m_we) m_data = mmem[m_addr[7:0]];
         end
      end
   end

   task automatic wait_until(input int t);
      do @(negedge clk); while (cyc < t);
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [3:0] rd, output int n);
      rif.req_valid = 1'b1;
      rif.req_we    = we;
      rif.req_addr  = addr;
      rif.req_wdata = wdata;
      rif.req_rd    = rd;
      n = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rif.req_ready) begin n = cyc; break; end
      end
      chk("accept_bound", n >= 0, 1);
      @(posedge clk); #1;
      rif.req_valid = 1'b0;
   endtask

   initial begin
      int n;
      int gap;
      logic [15:0] a;
      rif.req_valid = 0; rif.req_we = 0; rif.req_addr = 0; rif.req_wdata = 0; rif.req_rd = 0;
      rif1.req_valid = 0; rif1.req_we = 0; rif1.req_addr = 0; rif1.req_wdata = 0; rif1.req_rd = 0;
      rif1.resp_ready = 1'b1;

      // Reset held for 3 cycles
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {rif.req_ready, rif.resp_valid, mif.mem_en, mif.mem_we, rif.resp_err}, 0);
      chk("reset_data", rif.resp_data, 0);
      chk("reset_counters", {ld_cnt, st_cnt}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", rif.req_ready, 1);
      chk("post_reset_mem_en", mif.mem_en, 0);
      @(posedge clk); #1;

      // Store 0xBEEF to 0x10
      send(1'b1, 16'h0010, 16'hBEEF, 4'd2, n);
      wait_until(n + 1);
      chk("st_strobe", {mif.mem_en, mif.mem_we}, 2'b11);
      chk("st_addr", mif.mem_addr, 8'h10);
      chk("st_wdata", mif.mem_wdata, 16'hBEEF);
      wait_until(n + 2);
      chk("st_resp", {rif.resp_valid, rif.resp_err}, 2'b10);
      wait_until(n + 3);
      chk("st_cnt_one", st_cnt, 1);
      @(posedge clk); #1;

      // Load from 0x05, READ_LAT=3
      send(1'b0, 16'h0005, 16'h0, 4'd7, n);
      wait_until(n + 1);
      chk("ld_strobe", {mif.mem_en, mif.mem_we}, 2'b10);
      wait_until(n + 4);
      chk("ld_not_early", rif.resp_valid, 0);
      wait_until(n + 5);
      chk("ld_resp_valid", rif.resp_valid, 1);
      chk("ld_resp_data", rif.resp_data, 16'h1234);
      chk("ld_resp_rd", rif.resp_rd, 7);
      wait_until(n + 6);
      chk("ld_cnt_one", ld_cnt, 1);
      @(posedge clk); #1;

      // Out-of-range load
      send(1'b0, 16'h0100, 16'h0, 4'd3, n);
      wait_until(n + 1);
      chk("err_no_mem_en", mif.mem_en, 0);
      chk("err_resp", {rif.resp_valid, rif.resp_err}, 2'b11);
      chk("err_resp_data", rif.resp_data, 0);
      wait_until(n + 2);
      chk("err_cnt_one", err_cnt, 1);
      @(posedge clk); #1;

      // Load through the READ_LAT=1 instance
      rif1.req_valid = 1'b1; rif1.req_we = 1'b0; rif1.req_addr = 16'h0005; rif1.req_rd = 4'd7;
      n = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rif1.req_ready) begin n = cyc; break; end
      end
      chk("rl1_accept_bound", n >= 0, 1);
      @(posedge clk); #1;
      rif1.req_valid = 1'b0;
      wait_until(n + 2);
      chk("rl1_not_early", rif1.resp_valid, 0);
      wait_until(n + 3);
      chk("rl1_resp_valid", rif1.resp_valid, 1);
      chk("rl1_resp_data", rif1.resp_data, 16'h1234);
      chk("rl1_resp_rd", rif1.resp_rd, 7);
      wait_until(n + 4);
      chk("rl1_ld_cnt", ld_cnt1, 1);
      @(posedge clk); #1;

      // Backpressure: response held 4 cycles with a load pending behind it
      rr_mode = 2;
      send(1'b1, 16'h0020, 16'hA5A5, 4'd1, n);
      rif.req_valid = 1'b1; rif.req_we = 1'b0; rif.req_addr = 16'h0020; rif.req_rd = 4'd9;
      for (int k = 2; k <= 5; k++) begin
         wait_until(n + k);
         chk("bp_hold_valid", {rif.resp_valid, rif.req_ready}, 2'b10);
         chk("bp_hold_payload", {rif.resp_we, rif.resp_err, rif.resp_rd, rif.resp_data}, {2'b10, 4'd1, 16'h0});
      end
      @(posedge clk); #1;
      rr_mode = 0;
      wait_until(n + 6);
      chk("bp_hs_not_ready", rif.req_ready, 0);
      wait_until(n + 7);
      chk("bp_accept_after_hs", rif.req_ready, 1);
      @(posedge clk); #1;
      rif.req_valid = 1'b0;
      wait_until(n + 12);
      chk("bp_load_data", {rif.resp_valid, rif.resp_data, rif.resp_rd}, {1'b1, 16'hA5A5, 4'd9});
      wait_until(n + 13);
      chk("bp_counts", {ld_cnt, st_cnt}, {16'd2, 16'd2});
      @(posedge clk); #1;

      // Reset during LD_WAIT, then a clean load
      send(1'b0, 16'h0005, 16'h0, 4'd4, n);
      wait_until(n + 2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rst_mid_no_resp", rif.resp_valid, 0);
      end
      chk("rst_mid_counters", {ld_cnt, st_cnt, err_cnt}, 0);
      @(posedge clk); #1;
      send(1'b0, 16'h0005, 16'h0, 4'd4, n);
      wait_until(n + 5);
      chk("rst_mid_reload", {rif.resp_valid, rif.resp_data}, {1'b1, 16'h1234});
      wait_until(n + 6);
      chk("rst_mid_ld_cnt", ld_cnt, 1);
      @(posedge clk); #1;

      // Randomized traffic with random backpressure and gaps
      rr_mode = 1;
      for (int t = 0; t < 400; t++) begin
         gap = $urandom % 3;
         repeat (gap) begin @(posedge clk); #1; end
         case ($urandom % 8)
            0:       a = 16'h00FF;
            1:       a = 16'h0100;
            2:       a = 16'(16'h0100 + ($urandom % 16'hFF00));
            3:       a = 16'hFFFF;
            default: a = 16'($urandom % 32);
         endcase
         send(1'($urandom % 2), a, 16'($urandom), 4'($urandom), n);
      end
      rr_mode = 0;
      n = 0;
      while (m_busy && n < 100) begin @(negedge clk); n++; end
      chk("drain_bound", m_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
